counter_updn: RTL and testbench

- Parametrised successor to the basic clear/enable counter.
- Adds an up/down direction, a synchronous parallel load, and a programmable modulo (terminal value).
- Selectable wrap or saturate at the bounds, plus a registered overflow/underflow event pulse.
- Used as a general timer/index counter in sandbox designs; single clock domain, no handshake partner.

---
 rtl/counter_updn_pkg.sv | 28 ++
 rtl/counter_updn.sv | 89 ++++++++
 tb/tb_counter_updn.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/counter_updn_pkg.sv
// ============================================================================
//  counter_updn_pkg : step encoding shared by the up/down modulo counter
//  Revision: 1.0
// ============================================================================
`default_nettype none

package counter_updn_pkg;

    // What the counter does on a given clock edge, in decreasing priority.
    typedef enum logic [2:0] {
        STEP_HOLD = 3'd0,
        STEP_CLR  = 3'd1,
        STEP_LOAD = 3'd2,
        STEP_INC  = 3'd3,
        STEP_DEC  = 3'd4
    } step_e;

    function automatic step_e select_step(input logic clr, input logic load,
                                          input logic en,  input logic up);
        if (clr)       return STEP_CLR;
        else if (load) return STEP_LOAD;
        else if (en)   return up ? STEP_INC : STEP_DEC;
        else           return STEP_HOLD;
    endfunction

endpackage

`default_nettype wire

// File: rtl/counter_updn.sv
// ============================================================================
//  counter_updn : up/down counter with load, programmable modulo, wrap or
//                 saturate at the bounds, and registered ovf/unf pulses
//  Revision: 1.0
// ============================================================================
`default_nettype none

module counter_updn
    import counter_updn_pkg::*;
#(
    parameter int CNTR_WIDTH = 8,
    parameter int CNTR_MAX   = 2**CNTR_WIDTH - 1,
    parameter int SATURATE   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [CNTR_WIDTH-1:0] load_val,
    output logic [CNTR_WIDTH-1:0] cnt,
    output logic                  at_max,
    output logic                  at_zero,
    output logic                  ovf,
    output logic                  unf
);

    localparam logic [CNTR_WIDTH-1:0] MAX_C  = CNTR_WIDTH'(CNTR_MAX);
    localparam logic [CNTR_WIDTH-1:0] ONE_C  = CNTR_WIDTH'(1);
    localparam logic [CNTR_WIDTH-1:0] ZERO_C = '0;
    localparam logic                  SAT_C  = (SATURATE != 0);

    logic [CNTR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    step_e                 step;

    assign step = select_step(clr, load, en, up);

    // Bound steps never form cnt+1 / cnt-1, so no value outside 0..MAX is built.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        case (step)
            STEP_CLR:  cnt_d = ZERO_C;
            STEP_LOAD: cnt_d = (load_val > MAX_C) ? MAX_C : load_val;
            STEP_INC: begin
                if (cnt_q == MAX_C) begin
                    ovf_d = 1'b1;
                    cnt_d = SAT_C ? MAX_C : ZERO_C;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            STEP_DEC: begin
                if (cnt_q == ZERO_C) begin
                    unf_d = 1'b1;
                    cnt_d = SAT_C ? ZERO_C : MAX_C;
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= ZERO_C;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign cnt     = cnt_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;
    assign at_max  = (cnt_q == MAX_C);
    assign at_zero = (cnt_q == ZERO_C);

endmodule

`default_nettype wire

// File: tb/tb_counter_updn.sv
// ============================================================================
//  tb_counter_updn : directed bench for counter_updn (wrap, saturate, legacy)
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_counter_updn;

    logic       clk = 1'b0;
    logic       rst_n, clr, en, up, load;
    logic [2:0] load_val;

    logic [2:0] cnt_w, cnt_s, cnt_l;
    logic       atmax_w, atzero_w, ovf_w, unf_w;
    logic       atmax_s, atzero_s, ovf_s, unf_s;
    logic       atmax_l, atzero_l, ovf_l, unf_l;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    counter_updn #(.CNTR_WIDTH(3), .CNTR_MAX(5), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .up(up), .load(load),
        .load_val(load_val), .cnt(cnt_w), .at_max(atmax_w), .at_zero(atzero_w),
        .ovf(ovf_w), .unf(unf_w));

    counter_updn #(.CNTR_WIDTH(3), .CNTR_MAX(5), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .up(up), .load(load),
        .load_val(load_val), .cnt(cnt_s), .at_max(atmax_s), .at_zero(atzero_s),
        .ovf(ovf_s), .unf(unf_s));

    counter_updn #(.CNTR_WIDTH(3), .CNTR_MAX(7), .SATURATE(0)) u_leg (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .up(up), .load(load),
        .load_val(load_val), .cnt(cnt_l), .at_max(atmax_l), .at_zero(atzero_l),
        .ovf(ovf_l), .unf(unf_l));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; load_val = 3'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        #1;
        n_tests++;
        if ({cnt_w, cnt_s, cnt_l} !== 9'd0) begin
            n_fail++; $display("FAIL reset_cnt got %0h/%0h/%0h exp 0", cnt_w, cnt_s, cnt_l);
        end
        n_tests++;
        if ({ovf_w, unf_w, ovf_s, unf_s, ovf_l, unf_l} !== 6'd0) begin
            n_fail++; $display("FAIL reset_pulses got %b%b%b%b%b%b exp 0",
                               ovf_w, unf_w, ovf_s, unf_s, ovf_l, unf_l);
        end
        n_tests++;
        if ({atzero_w, atmax_w} !== 2'b10) begin
            n_fail++; $display("FAIL reset_flags at_zero=%b at_max=%b exp 1/0", atzero_w, atmax_w);
        end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_count();
        clr = 1'b1; tick(); idle();
        en = 1'b1; up = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (cnt_w !== 3'd3) begin
            n_fail++; $display("FAIL midreset_pre cnt got %0d exp 3", cnt_w);
        end
        idle();
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (cnt_w !== 3'd0 || atzero_w !== 1'b1 || ovf_w !== 1'b0 || unf_w !== 1'b0) begin
            n_fail++; $display("FAIL midreset cnt=%0d at_zero=%b ovf=%b unf=%b exp 0/1/0/0",
                               cnt_w, atzero_w, ovf_w, unf_w);
        end
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_up_wrap();
        int exp_c [7] = '{1, 2, 3, 4, 5, 0, 1};
        int exp_o [7] = '{0, 0, 0, 0, 0, 1, 0};
        clr = 1'b1; tick(); idle();
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            n_tests++;
            if (cnt_w !== 3'(exp_c[i]) || ovf_w !== 1'(exp_o[i]) || unf_w !== 1'b0) begin
                n_fail++; $display("FAIL up_wrap[%0d] cnt=%0d ovf=%b unf=%b exp %0d/%0d/0",
                                   i, cnt_w, ovf_w, unf_w, exp_c[i], exp_o[i]);
            end
        end
        idle();
    endtask

    task automatic test_down_wrap();
        int exp_c [3] = '{0, 5, 4};
        int exp_u [3] = '{0, 1, 0};
        load = 1'b1; load_val = 3'd1; tick(); idle();
        en = 1'b1; up = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (cnt_w !== 3'(exp_c[i]) || unf_w !== 1'(exp_u[i]) || ovf_w !== 1'b0) begin
                n_fail++; $display("FAIL down_wrap[%0d] cnt=%0d unf=%b ovf=%b exp %0d/%0d/0",
                                   i, cnt_w, unf_w, ovf_w, exp_c[i], exp_u[i]);
            end
        end
        idle();
    endtask

    task automatic test_saturate();
        int exp_o [3] = '{0, 1, 1};
        load = 1'b1; load_val = 3'd4; tick(); idle();
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (cnt_s !== 3'd5 || ovf_s !== 1'(exp_o[i]) || atmax_s !== 1'b1) begin
                n_fail++; $display("FAIL sat_up[%0d] cnt=%0d ovf=%b at_max=%b exp 5/%0d/1",
                                   i, cnt_s, ovf_s, atmax_s, exp_o[i]);
            end
        end
        idle();
        clr = 1'b1; tick(); idle();
        n_tests++;
        if (ovf_s !== 1'b0 || cnt_s !== 3'd0) begin
            n_fail++; $display("FAIL sat_clr cnt=%0d ovf=%b exp 0/0", cnt_s, ovf_s);
        end
        en = 1'b1; up = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if (cnt_s !== 3'd0 || unf_s !== 1'b1 || ovf_s !== 1'b0) begin
                n_fail++; $display("FAIL sat_down[%0d] cnt=%0d unf=%b ovf=%b exp 0/1/0",
                                   i, cnt_s, unf_s, ovf_s);
            end
        end
        idle();
        tick();
        n_tests++;
        if (unf_s !== 1'b0 || cnt_s !== 3'd0) begin
            n_fail++; $display("FAIL sat_hold cnt=%0d unf=%b exp 0/0", cnt_s, unf_s);
        end
    endtask

    task automatic test_load_priority();
        load = 1'b1; load_val = 3'd7; tick(); idle();
        n_tests++;
        if (cnt_w !== 3'd5 || atmax_w !== 1'b1) begin
            n_fail++; $display("FAIL load_clamp cnt=%0d at_max=%b exp 5/1", cnt_w, atmax_w);
        end
        load = 1'b1; en = 1'b1; up = 1'b1; load_val = 3'd2; tick(); idle();
        n_tests++;
        if (cnt_w !== 3'd2 || ovf_w !== 1'b0) begin
            n_fail++; $display("FAIL load_over_en cnt=%0d ovf=%b exp 2/0", cnt_w, ovf_w);
        end
        clr = 1'b1; load = 1'b1; en = 1'b1; load_val = 3'd3; tick(); idle();
        n_tests++;
        if (cnt_w !== 3'd0 || atzero_w !== 1'b1) begin
            n_fail++; $display("FAIL clr_over_load cnt=%0d at_zero=%b exp 0/1", cnt_w, atzero_w);
        end
        en = 1'b1; up = 1'b0; tick();
        load = 1'b1; load_val = 3'd3; tick(); idle();
        n_tests++;
        if (cnt_w !== 3'd3 || unf_w !== 1'b0) begin
            n_fail++; $display("FAIL load_clears_unf cnt=%0d unf=%b exp 3/0", cnt_w, unf_w);
        end
    endtask

    task automatic test_legacy();
        int pulses = 0;
        clr = 1'b1; tick(); idle();
        en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (ovf_l) pulses++;
            n_tests++;
            if (cnt_l !== 3'(k % 8) || ovf_l !== ((k % 8) == 0)) begin
                n_fail++; $display("FAIL legacy[%0d] cnt=%0d ovf=%b exp %0d/%0d",
                                   k, cnt_l, ovf_l, k % 8, (k % 8) == 0);
            end
        end
        idle();
        n_tests++;
        if (pulses != 2) begin
            n_fail++; $display("FAIL legacy_pulses got %0d exp 2", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_count();
        test_up_wrap();
        test_down_wrap();
        test_saturate();
        test_load_priority();
        test_legacy();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
